// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : Shared FSM encoding, write-mode constants and byte-merge helper
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int WRM_ZERO    = 0;
  localparam int WRM_THROUGH = 1;

  // Widest word the merge helper handles; callers cast down to their own width.
  localparam int MAX_DATA_W = 256;

  typedef logic [MAX_DATA_W-1:0]   word_t;
  typedef logic [MAX_DATA_W/8-1:0] bemask_t;

  function automatic word_t merge_word(input word_t old_w, input word_t new_w,
                                       input bemask_t be);
    word_t m;
    m = old_w;
    for (int k = 0; k < MAX_DATA_W/8; k++) begin
      if (be[k]) m[8*k +: 8] = new_w[8*k +: 8];
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_be_core.sv
// ============================================================================
// Module      : ram_be_core
// Description : Storage array with byte-masked write port and registered read
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_be_core
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;

  assign w_old    = r_mem[addr];
  assign w_merged = DATA_W'(merge_word(word_t'(w_old), word_t'(wdata), bemask_t'(be)));

  // A write also loads the merged word so write-through mode can present it.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= w_merged;
      rdata       <= w_merged;
    end else if (re) begin
      rdata       <= w_old;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_be_clr.sv
// ============================================================================
// Module      : ram_be_clr
// Description : Byte-enable single-port RAM with clear engine and range flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_be_clr
  import ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int WR_MODE = WRM_ZERO
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cen,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic                clr,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid,
  output logic                busy,
  output logic                err
);

  localparam logic [ADDR_W:0]   c_depth      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last       = ADDR_W'(DEPTH-1);
  localparam logic              c_wr_through = (WR_MODE == WRM_THROUGH);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_dout_en;
  logic                r_rvalid;
  logic                r_err;

  logic                w_clearing;
  logic                w_in_range;
  logic                w_acc;
  logic                w_user_wr;
  logic                w_user_rd;
  logic                w_oor;
  logic                w_core_we;
  logic [ADDR_W-1:0]   w_core_addr;
  logic [DATA_W-1:0]   w_core_wdata;
  logic [DATA_W/8-1:0] w_core_be;
  logic [DATA_W-1:0]   w_rdata;

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_in_range = ({1'b0, addr} < c_depth);
  // clr in IDLE takes priority and drops any concurrent access.
  assign w_acc      = !w_clearing && cen && !clr;
  assign w_user_wr  = w_acc && wen && w_in_range;
  assign w_user_rd  = w_acc && !wen && w_in_range;
  assign w_oor      = w_acc && !w_in_range;

  assign w_core_we    = w_clearing || w_user_wr;
  assign w_core_addr  = w_clearing ? r_ptr : addr;
  assign w_core_wdata = w_clearing ? '0 : din;
  assign w_core_be    = w_clearing ? '1 : be;

  ram_be_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .we    (w_core_we),
    .re    (w_user_rd),
    .addr  (w_core_addr),
    .wdata (w_core_wdata),
    .be    (w_core_be),
    .rdata (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_ptr == c_last) w_next = ST_IDLE;
      ST_IDLE:  if (clr)             w_next = ST_CLEAR;
      default:                       w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_clearing) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end else if (clr) begin
      r_ptr <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout_en <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_dout_en <= w_user_rd || (w_user_wr && c_wr_through);
      r_rvalid  <= w_user_rd;
      r_err     <= w_oor;
    end
  end

  // Core data register is left unreset; the enable flag zeroes dout instead.
  assign dout   = r_dout_en ? w_rdata : '0;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign busy   = w_clearing;

endmodule

`default_nettype wire

// File: tb/tb_ram_be_clr.sv
// ============================================================================
// Module      : tb_ram_be_clr
// Description : Self-checking bench: DUT A (DEPTH 32, zero-on-write) and DUT B (DEPTH 20, write-through)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_be_clr;

  typedef struct {
    logic        cen;
    logic        wen;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        clr;
    logic [31:0] dout;
    logic        rvalid;
    logic        err;
    logic        busy;
  } vec_t;

  typedef struct {
    bit          sel;
    int          id;
    logic [31:0] dout;
    logic        rvalid;
    logic        err;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_cen, a_wen, a_clr, b_cen, b_wen, b_clr;
  logic [3:0]  a_be, b_be;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din, a_dout, b_dout;
  logic        a_rvalid, a_busy, a_err, b_rvalid, b_busy, b_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  vec_t ta[12];
  vec_t tb[11];

  always #5 clk = ~clk;

  ram_be_clr #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .WR_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .cen(a_cen), .wen(a_wen), .be(a_be), .addr(a_addr),
    .din(a_din), .clr(a_clr), .dout(a_dout), .rvalid(a_rvalid), .busy(a_busy), .err(a_err)
  );

  ram_be_clr #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .WR_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .cen(b_cen), .wen(b_wen), .be(b_be), .addr(b_addr),
    .din(b_din), .clr(b_clr), .dout(b_dout), .rvalid(b_rvalid), .busy(b_busy), .err(b_err)
  );

  function automatic vec_t mk(input logic cen, input logic wen, input logic [3:0] be,
                              input logic [4:0] addr, input logic [31:0] din,
                              input logic [31:0] dout, input logic rvalid, input logic err);
    vec_t v;
    v.cen = cen; v.wen = wen; v.be = be; v.addr = addr; v.din = din; v.clr = 1'b0;
    v.dout = dout; v.rvalid = rvalid; v.err = err; v.busy = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, id, act, expv);
    end
  endtask

  task automatic idle_inputs();
    a_cen = 0; a_wen = 0; a_be = 0; a_addr = 0; a_din = 0; a_clr = 0;
    b_cen = 0; b_wen = 0; b_be = 0; b_addr = 0; b_din = 0; b_clr = 0;
  endtask

  task automatic apply(input bit sel, input int id, input vec_t v);
    exp_t e;
    @(negedge clk);
    idle_inputs();
    if (!sel) begin
      a_cen = v.cen; a_wen = v.wen; a_be = v.be; a_addr = v.addr; a_din = v.din; a_clr = v.clr;
    end else begin
      b_cen = v.cen; b_wen = v.wen; b_be = v.be; b_addr = v.addr; b_din = v.din; b_clr = v.clr;
    end
    exp_q.push_back('{sel: sel, id: id, dout: v.dout, rvalid: v.rvalid, err: v.err, busy: v.busy});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (!e.sel) begin
      chk("a_dout", e.id, a_dout, e.dout);
      chk("a_rvalid", e.id, 32'(a_rvalid), 32'(e.rvalid));
      chk("a_err", e.id, 32'(a_err), 32'(e.err));
      chk("a_busy", e.id, 32'(a_busy), 32'(e.busy));
    end else begin
      chk("b_dout", e.id, b_dout, e.dout);
      chk("b_rvalid", e.id, 32'(b_rvalid), 32'(e.rvalid));
      chk("b_err", e.id, 32'(b_err), 32'(e.err));
      chk("b_busy", e.id, 32'(b_busy), 32'(e.busy));
    end
  endtask

  // Edges until each DUT's busy drops (-1 if it never does); reads are offered meanwhile.
  task automatic busy_len(input logic [4:0] raddr, output int la, output int lb);
    la = -1;
    lb = -1;
    for (int i = 1; i <= 200 && (la < 0 || lb < 0); i++) begin
      @(negedge clk);
      idle_inputs();
      a_cen = 1; a_addr = raddr; b_cen = 1; b_addr = raddr;
      @(posedge clk);
      #1;
      if (la < 0) begin
        if (!a_busy) la = i;
        else begin
          chk("a_rvalid_clr", i, 32'(a_rvalid), 32'd0);
          chk("a_dout_clr", i, a_dout, 32'd0);
        end
      end
      if (lb < 0) begin
        if (!b_busy) lb = i;
        else chk("b_rvalid_clr", i, 32'(b_rvalid), 32'd0);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int   la, lb;
    vec_t v;

    ta[0]  = mk(1, 0, 4'hF, 5,  32'h0,        32'h00000000, 1, 0);
    ta[1]  = mk(1, 1, 4'hF, 3,  32'hDEADBEEF, 32'h00000000, 0, 0);
    ta[2]  = mk(1, 0, 4'hF, 3,  32'h0,        32'hDEADBEEF, 1, 0);
    ta[3]  = mk(1, 1, 4'h5, 3,  32'h11223344, 32'h00000000, 0, 0);
    ta[4]  = mk(1, 0, 4'h0, 3,  32'h0,        32'hDE22BE44, 1, 0);
    ta[5]  = mk(1, 1, 4'h0, 3,  32'hFFFFFFFF, 32'h00000000, 0, 0);
    ta[6]  = mk(1, 0, 4'h0, 3,  32'h0,        32'hDE22BE44, 1, 0);
    ta[7]  = mk(0, 0, 4'h0, 3,  32'h0,        32'h00000000, 0, 0);
    ta[8]  = mk(1, 1, 4'hF, 31, 32'hCAFEF00D, 32'h00000000, 0, 0);
    ta[9]  = mk(1, 0, 4'h0, 31, 32'h0,        32'hCAFEF00D, 1, 0);
    ta[10] = mk(1, 1, 4'h8, 7,  32'hA5A5A5A5, 32'h00000000, 0, 0);
    ta[11] = mk(1, 0, 4'h0, 7,  32'h0,        32'hA5000000, 1, 0);

    tb[0]  = mk(1, 1, 4'hF, 5,  32'h00000055, 32'h00000055, 0, 0);
    tb[1]  = mk(1, 0, 4'h0, 25, 32'h0,        32'h00000000, 0, 1);
    tb[2]  = mk(0, 0, 4'h0, 0,  32'h0,        32'h00000000, 0, 0);
    tb[3]  = mk(1, 1, 4'hF, 25, 32'hFFFFFFFF, 32'h00000000, 0, 1);
    tb[4]  = mk(1, 0, 4'h0, 5,  32'h0,        32'h00000055, 1, 0);
    tb[5]  = mk(1, 1, 4'hF, 3,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tb[6]  = mk(1, 1, 4'h5, 3,  32'h11223344, 32'hDE22BE44, 0, 0);
    tb[7]  = mk(1, 1, 4'h0, 3,  32'h00000000, 32'hDE22BE44, 0, 0);
    tb[8]  = mk(1, 0, 4'h0, 3,  32'h0,        32'hDE22BE44, 1, 0);
    tb[9]  = mk(1, 0, 4'h0, 19, 32'h0,        32'h00000000, 1, 0);
    tb[10] = mk(1, 0, 4'h0, 20, 32'h0,        32'h00000000, 0, 1);

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_dout", 0, a_dout, 32'd0);
    chk("rst_a_rvalid", 0, 32'(a_rvalid), 32'd0);
    chk("rst_a_err", 0, 32'(a_err), 32'd0);
    chk("rst_a_busy", 0, 32'(a_busy), 32'd1);
    chk("rst_b_busy", 0, 32'(b_busy), 32'd1);
    reset = 0;
    busy_len(5'd31, la, lb);
    chk("a_clear_len", 0, 32'(la), 32'd32);
    chk("b_clear_len", 0, 32'(lb), 32'd20);

    for (int i = 0; i < 12; i++) apply(0, i, ta[i]);

    // clr beats a concurrent read of the word just written
    v = mk(1, 0, 4'h0, 31, 32'h0, 32'h0, 0, 0);
    v.clr = 1; v.busy = 1;
    apply(0, 100, v);
    busy_len(5'd31, la, lb);
    chk("a_clr_len", 1, 32'(la), 32'd32);
    apply(0, 101, mk(1, 0, 4'h0, 31, 32'h0, 32'h00000000, 1, 0));

    // asynchronous reset while dout holds data
    apply(0, 102, mk(1, 1, 4'hF, 3, 32'h12345678, 32'h00000000, 0, 0));
    apply(0, 103, mk(1, 0, 4'h0, 3, 32'h0, 32'h12345678, 1, 0));
    reset = 1;
    #1;
    chk("async_a_dout", 2, a_dout, 32'd0);
    chk("async_a_rvalid", 2, 32'(a_rvalid), 32'd0);
    chk("async_a_busy", 2, 32'(a_busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 0;
    busy_len(5'd31, la, lb);
    chk("a_rst_len", 2, 32'(la), 32'd32);
    apply(0, 104, mk(1, 0, 4'h0, 3, 32'h0, 32'h00000000, 1, 0));

    // reset with the clear pointer at 10
    v = mk(0, 0, 4'h0, 0, 32'h0, 32'h0, 0, 0);
    v.clr = 1; v.busy = 1;
    apply(0, 105, v);
    @(negedge clk);
    idle_inputs();
    repeat (10) @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("mid_a_busy", 3, 32'(a_busy), 32'd1);
    chk("mid_a_dout", 3, a_dout, 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    busy_len(5'd31, la, lb);
    chk("a_mid_len", 3, 32'(la), 32'd32);

    for (int i = 0; i < 11; i++) apply(1, 200 + i, tb[i]);

    v = mk(1, 1, 4'hF, 3, 32'hFFFFFFFF, 32'h0, 0, 0);
    v.clr = 1; v.busy = 1;
    apply(1, 300, v);
    busy_len(5'd3, la, lb);
    chk("b_clr_len", 4, 32'(lb), 32'd20);
    apply(1, 301, mk(1, 0, 4'h0, 3, 32'h0, 32'h00000000, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
